pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_stage_skid_sat_counter.sv | 35 +++
 rtl/pipe_stage_skid.sv | 104 ++++++++++
 tb/tb_pipe_stage_skid.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage: stage occupancy states and the
// default performance-counter width.
package pipe_pkg;

   // Encoding equals the number of held words, so occupancy is the state itself.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter used for the stage performance counters.
module sat_counter
   import pipe_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: step on inc, stick at all-ones.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Count register, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage with flush, stall and performance
// counters. All outputs are decoded from registers only.
//
//  state    | meaning
//  ---------+-------------------------------------------------
//  ST_EMPTY | nothing held; out_valid=0, in_ready=1
//  ST_ONE   | main holds the live word; full throughput
//  ST_FULL  | main and skid both held; input blocked
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int                DATA_W    = 64,
   parameter int                CNT_W     = CNT_W_DEF,
   parameter logic [DATA_W-1:0] FLUSH_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   input  logic              stall,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   state_t            state_q;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] skid_q;

   logic in_xfer;
   logic out_xfer;
   logic stall_inc;

   assign out_valid = (state_q != ST_EMPTY);
   assign in_ready  = (state_q != ST_FULL);
   assign out_data  = main_q;
   assign occupancy = state_q;

   assign in_xfer   = in_valid && in_ready && !flush;
   assign out_xfer  = out_valid && out_ready && !stall && !flush;
   // A flush cycle discards the word, so it is not counted as a blocked output.
   assign stall_inc = out_valid && !flush && (!out_ready || stall);

   // Occupancy FSM with main/skid payload registers; flush overrides everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         main_q  <= FLUSH_VAL;
         skid_q  <= FLUSH_VAL;
      end else if (flush) begin
         state_q <= ST_EMPTY;
         main_q  <= FLUSH_VAL;
         skid_q  <= FLUSH_VAL;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  state_q <= ST_ONE;
                  main_q  <= in_data;
               end
            end
            ST_ONE: begin
               if (in_xfer && out_xfer) begin
                  main_q  <= in_data;
               end else if (in_xfer) begin
                  state_q <= ST_FULL;
                  skid_q  <= in_data;
               end else if (out_xfer) begin
                  state_q <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_xfer) begin
                  state_q <= ST_ONE;
                  main_q  <= skid_q;
               end
            end
            default: begin
               state_q <= ST_EMPTY;
            end
         endcase
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: streaming, skid fill, flush priority,
// asynchronous reset and counter saturation.
module tb_pipe_stage_skid;

   localparam int          DATA_W = 64;
   localparam int          CNT_W  = 4;
   localparam logic [63:0] FV     = 64'h0000_0000_DEAD_BEEF;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              flush;
   logic              stall;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   int n_cmp = 0;
   int n_err = 0;

   pipe_stage_skid #(
      .DATA_W    (DATA_W),
      .CNT_W     (CNT_W),
      .FLUSH_VAL (FV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .flush     (flush),
      .stall     (stall),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] d, input logic ordy,
                        input logic stl, input logic fl);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      stall     = stl;
      flush     = fl;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      #3;
      // reset state
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_occ",       64'(occupancy), 64'd0);
      chk("rst_out_data",  out_data,       FV);
      chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // streaming 1..5 with out_ready=1
      for (int k = 1; k <= 5; k++) begin
         drive(1'b1, 64'(k), 1'b1, 1'b0, 1'b0);
         tick();
         chk("stream_data", out_data, 64'(k));
         chk("stream_occ",  64'(occupancy), 64'd1);
      end
      drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
      tick();
      chk("stream_drain_valid", 64'(out_valid), 64'd0);
      chk("stream_stall_cnt",   64'(stall_cnt), 64'd0);

      // skid fill
      drive(1'b1, 64'hA, 1'b1, 1'b0, 1'b0);
      tick();
      chk("skid_a_data", out_data, 64'hA);
      drive(1'b1, 64'hB, 1'b1, 1'b1, 1'b0);
      tick();
      chk("skid_full_occ",   64'(occupancy), 64'd2);
      chk("skid_full_ready", 64'(in_ready),  64'd0);
      chk("skid_full_data",  out_data,       64'hA);
      chk("skid_stall_1",    64'(stall_cnt), 64'd1);
      drive(1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
      tick();
      chk("skid_hold_data",  out_data,       64'hA);
      chk("skid_stall_2",    64'(stall_cnt), 64'd2);
      drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
      tick();
      chk("skid_b_data",   out_data,       64'hB);
      chk("skid_b_occ",    64'(occupancy), 64'd1);
      chk("skid_stall_fin", 64'(stall_cnt), 64'd2);
      tick();
      chk("skid_drain_valid", 64'(out_valid), 64'd0);

      // flush priority from FULL
      drive(1'b1, 64'h11, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 64'h12, 1'b0, 1'b0, 1'b0);
      tick();
      chk("fl_pre_occ",   64'(occupancy), 64'd2);
      chk("fl_pre_stall", 64'(stall_cnt), 64'd3);
      drive(1'b1, 64'hC, 1'b1, 1'b1, 1'b1);
      tick();
      chk("fl_valid",     64'(out_valid), 64'd0);
      chk("fl_data",      out_data,       FV);
      chk("fl_occ",       64'(occupancy), 64'd0);
      chk("fl_cnt",       64'(flush_cnt), 64'd1);
      chk("fl_stall_cnt", 64'(stall_cnt), 64'd3);
      drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
      tick();
      chk("fl_no_c_valid", 64'(out_valid), 64'd0);
      chk("fl_no_c_data",  out_data,       FV);

      // asynchronous reset while ONE
      drive(1'b1, 64'h21, 1'b0, 1'b0, 1'b0);
      tick();
      chk("ar_pre_valid", 64'(out_valid), 64'd1);
      #3;
      rst = 1'b1;
      #1;
      chk("ar_valid",     64'(out_valid), 64'd0);
      chk("ar_ready",     64'(in_ready),  64'd1);
      chk("ar_data",      out_data,       FV);
      chk("ar_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("ar_flush_cnt", 64'(flush_cnt), 64'd0);
      #1;
      rst = 1'b0;
      drive(1'b1, 64'hD, 1'b1, 1'b0, 1'b0);
      tick();
      chk("ar_d_valid", 64'(out_valid), 64'd1);
      chk("ar_d_data",  out_data,       64'hD);
      chk("ar_d_occ",   64'(occupancy), 64'd1);

      // stall counter saturation: D stays held with out_ready=0
      drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 14) chk("sat_mid", 64'(stall_cnt), 64'd14);
      end
      chk("sat_end",  64'(stall_cnt), 64'd15);
      chk("sat_data", out_data,       64'hD);
      chk("sat_occ",  64'(occupancy), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
